regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rd_addr  input  NRD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data  output  NRD*DATA_W  registered read data, packed the same way as rd_addr.
REQ-008 SHALL have port rd_busy  output  NRD  registered pending-write flag per read port.
REQ-009 SHALL have port hold  input  1  freeze rd_data/rd_busy.
REQ-010 SHALL have port clear  input  1  zero rd_data/rd_busy (pipeline flush).
REQ-011 SHALL have ports wr0_en/wr1_en  input  1  write enables.
REQ-012 SHALL have ports wr0_addr/wr1_addr  input  ADDR_W  write addresses.
REQ-013 SHALL have ports wr0_data/wr1_data  input  DATA_W  write data.
REQ-014 SHALL have port sb_set_en  input  1  mark a register as pending (producer issued).
REQ-015 SHALL have port sb_set_addr  input  ADDR_W  register to mark pending.
REQ-016 SHALL have port busy_vec  output  NREG  registered scoreboard, bit r = register r pending.

Function
REQ-017 Read latency SHALL be exactly 1 cycle: rd_addr sampled at edge N, rd_data valid after edge N.
REQ-018 Register 0 SHALL read as 0, ignore writes, never become busy.
REQ-019 Write with wrX_en=1 SHALL update storage at the edge; wr1 SHALL win when wr0_addr == wr1_addr.
REQ-020 Read of an address written in the same cycle SHALL return the new data (wr1 over wr0), not stale storage.
REQ-021 Priority per read port, highest first: clear (data 0, busy 0), hold (retain), addr 0 (data 0, busy 0), forwarded write, storage.
REQ-022 Writes and scoreboard updates SHALL proceed regardless of hold/clear.
REQ-023 busy bit r SHALL clear on a write to r and set on sb_set_en to r; same-cycle set and write to r SHALL leave r set.
REQ-024 rd_busy[p] SHALL reflect busy_vec after the same-cycle update for the sampled address.
REQ-025 While hold=1, rd_data SHALL NOT track later writes to the held address; new value visible after the first non-hold read.
REQ-026 All NRD ports SHALL operate independently; identical addresses on several ports SHALL return identical results.

Reset
REQ-027 reset SHALL set rd_data=0, rd_busy=0, busy_vec=0 at the next edge; reset SHALL override clear, hold, sb_set_en.
REQ-028 Storage contents SHALL NOT be altered by reset; storage SHALL be initialised to 0 at configuration.
REQ-029 Writes asserted during reset SHALL still update storage.

Structure
REQ-030 Shared package regfile_pkg SHALL hold default DATA_W/ADDR_W/NRD constants and the port-slice helper widths.
REQ-031 One sub-module regfile_rdport (forwarding mux, zero/hold/clear priority, output registers) SHALL be instantiated NRD times via generate.
REQ-032 Storage SHALL be a plain array inferable as distributed RAM; no reset on the array.

Verification
REQ-033 Write r3=0x12345678 via wr0, next cycle read port0 r3 -> rd_data0=0x12345678 one cycle later.
REQ-034 Same cycle wr0 r5=0xAAAA, wr1 r5=0xBBBB, read r5 on both ports -> both return 0xBBBB; later storage read r5=0xBBBB.
REQ-035 Write r0=0xFFFFFFFF and sb_set r0, read r0 -> rd_data=0, rd_busy=0, busy_vec[0]=0.
REQ-036 sb_set r7; next cycle read r7 -> rd_busy=1; write r7=0x55 with sb_set r7 same cycle -> busy_vec[7]=1 and read returns 0x55.
REQ-037 Read r2=0x11, assert hold 3 cycles while writing r2=0x22 -> rd_data stays 0x11; drop hold -> 0x22 next cycle; clear -> 0.
REQ-038 Load r4=0x99, sb_set r4, pulse reset -> busy_vec=0, rd_data=0, subsequent read r4=0x99.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and helpers for locating
// one read port's slice within the packed address/data buses.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NRD    = 2;

  localparam int DEF_RD_ADDR_BITS = DEF_NRD * DEF_ADDR_W;
  localparam int DEF_RD_DATA_BITS = DEF_NRD * DEF_DATA_W;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: same-cycle write forwarding, register-0 zeroing,
// hold/clear priority and the output data/busy registers.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              busy_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic [DATA_W-1:0] fwd_data;

  // wr1 is checked first so it wins when both write ports hit this address.
  always_comb begin
    fwd_data = mem_data;
    if (wr1_en && (wr1_addr == addr)) begin
      fwd_data = wr1_data;
    end else if (wr0_en && (wr0_addr == addr)) begin
      fwd_data = wr0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (hold) begin
      rd_data <= rd_data;
      rd_busy <= rd_busy;
    end else if (addr == '0) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else begin
      rd_data <= fwd_data;
      rd_busy <= busy_in;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a pending-write scoreboard;
// register 0 is hardwired to zero and never marked busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  hold,
  input  logic                  clear,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic                  sb_set_en,
  input  logic [ADDR_W-1:0]     sb_set_addr,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int NREG = 2 ** ADDR_W;

  // Storage is left out of reset so it can map onto distributed RAM.
  logic [DATA_W-1:0] mem [NREG] = '{default: '0};
  logic [NREG-1:0]   busy_next;

  always_ff @(posedge clk) begin
    if (wr0_en && (wr0_addr != '0)) begin
      mem[wr0_addr] <= wr0_data;
    end
    if (wr1_en && (wr1_addr != '0)) begin
      mem[wr1_addr] <= wr1_data;
    end
  end

  // Writes retire a pending entry; a same-cycle issue to that register wins.
  always_comb begin
    busy_next = busy_vec;
    if (wr0_en) begin
      busy_next[wr0_addr] = 1'b0;
    end
    if (wr1_en) begin
      busy_next[wr1_addr] = 1'b0;
    end
    if (sb_set_en) begin
      busy_next[sb_set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rdport
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];

    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .clk      (clk),
      .reset    (reset),
      .hold     (hold),
      .clear    (clear),
      .addr     (port_addr),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .mem_data (mem[port_addr]),
      .busy_in  (busy_next[port_addr]),
      .rd_data  (rd_data[slice_lo(p, DATA_W) +: DATA_W]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read ports; each step is one clock
// edge followed by hand-computed checks.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NRD    = 2;
  localparam int NREG   = 2 ** ADDR_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  hold;
  logic                  clear;
  logic                  wr0_en;
  logic [ADDR_W-1:0]     wr0_addr;
  logic [DATA_W-1:0]     wr0_data;
  logic                  wr1_en;
  logic [ADDR_W-1:0]     wr1_addr;
  logic [DATA_W-1:0]     wr1_data;
  logic                  sb_set_en;
  logic [ADDR_W-1:0]     sb_set_addr;
  logic [NREG-1:0]       busy_vec;

  int compared   = 0;
  int mismatched = 0;

  regfile_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .hold        (hold),
    .clear       (clear),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  // Inputs are set 1ns after an edge, so the next call captures them.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    hold        = 1'b0;
    clear       = 1'b0;
    wr0_en      = 1'b0;
    wr0_addr    = '0;
    wr0_data    = '0;
    wr1_en      = 1'b0;
    wr1_addr    = '0;
    wr1_data    = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
  endtask

  function automatic logic [NRD*ADDR_W-1:0] addrs(input logic [ADDR_W-1:0] a0,
                                                  input logic [ADDR_W-1:0] a1);
    return {a1, a0};
  endfunction

  initial begin
    idleInputs();
    reset   = 1'b1;
    rd_addr = '0;
    applyStimulus();
    checkOutput("reset_rd_data0", 64'(rd_data[31:0]), 64'h0);
    checkOutput("reset_rd_data1", 64'(rd_data[63:32]), 64'h0);
    checkOutput("reset_rd_busy", 64'(rd_busy), 64'h0);
    checkOutput("reset_busy_vec", 64'(busy_vec), 64'h0);
    reset = 1'b0;

    // Plain write then read one cycle later.
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h1234_5678;
    applyStimulus();
    idleInputs();
    rd_addr = addrs(4'd3, 4'd5);
    applyStimulus();
    checkOutput("wr_r3_rd_p0", 64'(rd_data[31:0]), 64'h1234_5678);
    checkOutput("unwritten_r5_rd_p1", 64'(rd_data[63:32]), 64'h0);

    // Both write ports hit r5 while both read ports forward it.
    wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'hAAAA;
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'hBBBB;
    rd_addr = addrs(4'd5, 4'd5);
    applyStimulus();
    checkOutput("fwd_r5_p0", 64'(rd_data[31:0]), 64'hBBBB);
    checkOutput("fwd_r5_p1", 64'(rd_data[63:32]), 64'hBBBB);
    idleInputs();
    applyStimulus();
    checkOutput("stored_r5_p0", 64'(rd_data[31:0]), 64'hBBBB);
    checkOutput("stored_r5_p1", 64'(rd_data[63:32]), 64'hBBBB);

    // Register 0 ignores writes and scoreboard sets.
    wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 32'hFFFF_FFFF;
    sb_set_en = 1'b1; sb_set_addr = 4'd0;
    rd_addr = addrs(4'd0, 4'd0);
    applyStimulus();
    checkOutput("r0_fwd_data", 64'(rd_data[31:0]), 64'h0);
    checkOutput("r0_rd_busy", 64'(rd_busy), 64'h0);
    checkOutput("r0_busy_vec", 64'(busy_vec), 64'h0);
    idleInputs();
    applyStimulus();
    checkOutput("r0_stored_data", 64'(rd_data[63:32]), 64'h0);

    // Scoreboard: set r7, observe pending, then write+set, then write only.
    sb_set_en = 1'b1; sb_set_addr = 4'd7;
    applyStimulus();
    checkOutput("sb_set_r7_vec", 64'(busy_vec), 64'h0080);
    idleInputs();
    rd_addr = addrs(4'd7, 4'd3);
    applyStimulus();
    checkOutput("r7_busy_p0", 64'(rd_busy), 64'b01);
    checkOutput("r7_data_p0", 64'(rd_data[31:0]), 64'h0);
    wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 32'h55;
    sb_set_en = 1'b1; sb_set_addr = 4'd7;
    applyStimulus();
    checkOutput("r7_set_and_wr_vec", 64'(busy_vec), 64'h0080);
    checkOutput("r7_set_and_wr_data", 64'(rd_data[31:0]), 64'h55);
    checkOutput("r7_set_and_wr_busy", 64'(rd_busy), 64'b01);
    idleInputs();
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h66;
    applyStimulus();
    checkOutput("r7_wr_clears_vec", 64'(busy_vec), 64'h0);
    checkOutput("r7_wr_clears_busy", 64'(rd_busy), 64'b00);
    checkOutput("r7_wr1_fwd_data", 64'(rd_data[31:0]), 64'h66);
    checkOutput("r3_p1_data", 64'(rd_data[63:32]), 64'h1234_5678);

    // Hold freezes port output across writes to the held address.
    idleInputs();
    wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h11;
    applyStimulus();
    idleInputs();
    rd_addr = addrs(4'd2, 4'd2);
    applyStimulus();
    checkOutput("r2_before_hold", 64'(rd_data[31:0]), 64'h11);
    hold = 1'b1;
    wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("r2_held_%0d", i), 64'(rd_data[31:0]), 64'h11);
    end
    idleInputs();
    applyStimulus();
    checkOutput("r2_after_hold", 64'(rd_data[31:0]), 64'h22);
    clear = 1'b1; hold = 1'b1;
    applyStimulus();
    checkOutput("clear_over_hold_p0", 64'(rd_data[31:0]), 64'h0);
    checkOutput("clear_over_hold_p1", 64'(rd_data[63:32]), 64'h0);
    idleInputs();

    // Reset clears outputs and scoreboard but not storage, and admits writes.
    wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 32'h99;
    sb_set_en = 1'b1; sb_set_addr = 4'd4;
    rd_addr = addrs(4'd3, 4'd4);
    applyStimulus();
    checkOutput("r4_pending_vec", 64'(busy_vec), 64'h0010);
    checkOutput("r4_fwd_p1", 64'(rd_data[63:32]), 64'h99);
    checkOutput("r4_busy_p1", 64'(rd_busy), 64'b10);
    idleInputs();
    reset = 1'b1; hold = 1'b1;
    sb_set_en = 1'b1; sb_set_addr = 4'd9;
    wr1_en = 1'b1; wr1_addr = 4'd9; wr1_data = 32'h77;
    applyStimulus();
    checkOutput("rst_busy_vec", 64'(busy_vec), 64'h0);
    checkOutput("rst_rd_data", 64'(rd_data), 64'h0);
    checkOutput("rst_rd_busy", 64'(rd_busy), 64'h0);
    reset = 1'b0;
    idleInputs();
    rd_addr = addrs(4'd4, 4'd9);
    applyStimulus();
    checkOutput("post_rst_r4", 64'(rd_data[31:0]), 64'h99);
    checkOutput("post_rst_r9", 64'(rd_data[63:32]), 64'h77);
    checkOutput("post_rst_vec", 64'(busy_vec), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
